// File: rtl/rca_pkg.sv
// rca_pkg: shared constants, FSM state type and slice-count helper for the
// sequential ripple-carry adder controller (rca_seq_ctrl) and its slice adder.
package rca_pkg;
    localparam int SLICE_W = 3;

    typedef enum logic [1:0] {IDLE, RUN, DONE} rca_seq_state_t;

    // Number of slice cycles needed for a given operand width.
    function automatic int rca_nslice(input int width);
        return width / SLICE_W;
    endfunction
endpackage

// File: rtl/rca_seq_ctrl_if.sv
// rca_seq_ctrl_if: operand/result handshake bundle for rca_seq_ctrl.
//   master: operand issuer / result consumer
//   slave : rca_seq_ctrl
// Signals: in_valid/in_ready/in_a/in_b/in_cin (operand handshake),
//          out_valid/out_ready/out_sum/out_cout (result handshake), busy.
// Optional macro RCA_SEQ_SUB_EN adds in_sub (subtract request).
interface rca_seq_ctrl_if #(parameter int WIDTH = 12);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
`ifdef RCA_SEQ_SUB_EN
    logic             in_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;

`ifdef RCA_SEQ_SUB_EN
    modport master (output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                    input  in_ready, out_valid, out_sum, out_cout, busy);
    modport slave  (input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
                    output in_ready, out_valid, out_sum, out_cout, busy);
`else
    modport master (output in_valid, in_a, in_b, in_cin, out_ready,
                    input  in_ready, out_valid, out_sum, out_cout, busy);
    modport slave  (input  in_valid, in_a, in_b, in_cin, out_ready,
                    output in_ready, out_valid, out_sum, out_cout, busy);
`endif
endinterface

// File: rtl/rca_seq_ctrl_slice3.sv
// rca_slice3: combinational SLICE_W-bit ripple-carry full-adder chain.
// Ports: i_a, i_b (slice operands), i_cin (carry in) -> o_sum, o_cout.
module rca_slice3
    import rca_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_cin,
    output logic [SLICE_W-1:0] o_sum,
    output logic               o_cout
);
    logic [SLICE_W:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1]   = (i_a[i] & i_b[i]) | (i_a[i] & w_c[i]) | (i_b[i] & w_c[i]);
    end

    assign o_cout = w_c[SLICE_W];
endmodule

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: multi-cycle WIDTH-bit adder built on one shared 3-bit slice
// adder. Operands are captured on the input handshake, one slice is summed per
// cycle LSB first with the carry held in a register, and the result is offered
// on the output handshake.
// Ports: clk, rst_n (async active-low), bus (rca_seq_ctrl_if.slave).
// Optional macro RCA_SEQ_SUB_EN: adds in_sub; when set, B is inverted per slice
// and the carry starts at 1, giving A-B with out_cout=1 meaning no borrow.
module rca_seq_ctrl
    import rca_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    rca_seq_ctrl_if.slave bus
);
    localparam int NSLICE = rca_nslice(WIDTH);
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
        $error("rca_seq_ctrl: WIDTH must be a non-zero multiple of SLICE_W");
    end

    rca_seq_state_t   r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic             r_carry, r_cout;
    logic [KW-1:0]    r_k;
`ifdef RCA_SEQ_SUB_EN
    logic             r_sub;
`endif

    logic               w_accept, w_last, w_cin_init;
    int                 w_idx;
    logic [SLICE_W-1:0] w_a_sl, w_b_sl, w_s_sl;
    logic               w_c_sl;

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_last   = (r_k == KW'(NSLICE - 1));

    always_comb begin
        w_idx  = int'(r_k) * SLICE_W;
        w_a_sl = r_a[w_idx +: SLICE_W];
`ifdef RCA_SEQ_SUB_EN
        w_b_sl = r_b[w_idx +: SLICE_W] ^ {SLICE_W{r_sub}};
`else
        w_b_sl = r_b[w_idx +: SLICE_W];
`endif
    end

`ifdef RCA_SEQ_SUB_EN
    // Subtraction is A + ~B + 1, so the incoming carry is forced to 1.
    assign w_cin_init = bus.in_sub ? 1'b1 : bus.in_cin;
`else
    assign w_cin_init = bus.in_cin;
`endif

    rca_slice3 u_slice (
        .i_a    (w_a_sl),
        .i_b    (w_b_sl),
        .i_cin  (r_carry),
        .o_sum  (w_s_sl),
        .o_cout (w_c_sl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath; r_sum is only partially overwritten per slice, so stale upper
    // slices of the previous result are visible until out_valid rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_k     <= '0;
`ifdef RCA_SEQ_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= bus.in_a;
            r_b     <= bus.in_b;
            r_carry <= w_cin_init;
            r_k     <= '0;
`ifdef RCA_SEQ_SUB_EN
            r_sub   <= bus.in_sub;
`endif
        end else if (r_state == RUN) begin
            r_sum[w_idx +: SLICE_W] <= w_s_sl;
            r_carry                 <= w_c_sl;
            r_k                     <= r_k + KW'(1);
            if (w_last) r_cout <= w_c_sl;
        end
    end

    assign bus.out_sum  = r_sum;
    assign bus.out_cout = r_cout;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb_rca_seq_ctrl: randomized + directed bench for rca_seq_ctrl with a
// scoreboard queue filled on operand acceptance and drained by an output monitor.
module tb_rca_seq_ctrl;
    localparam int W  = 12;
    localparam int NS = W / 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rca_seq_ctrl_if #(.WIDTH(W)) bus();
    rca_seq_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    exp_t sb_q[$];
    int   acc_q[$];
    int   n_chk = 0, n_pass = 0;
    int   cyc = 0, acc_edge = -1, hs_edge = -1;
    logic prev_ov = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference: plain integer arithmetic on the full-width operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t   e;
        longint s;
        if (sub) begin
            s      = (longint'(a) - longint'(b)) & ((longint'(1) << W) - 1);
            e.sum  = W'(s);
            e.cout = (a >= b);
        end else begin
            s      = longint'(a) + longint'(b) + longint'(cin);
            e.sum  = W'(s);
            e.cout = (s >= (longint'(1) << W));
        end
        return e;
    endfunction

    function automatic logic cur_sub();
`ifdef RCA_SEQ_SUB_EN
        return bus.in_sub;
`else
        return 1'b0;
`endif
    endfunction

    // Acceptance observer: pushes the expected result when an operand is taken.
    always @(posedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) begin
            sb_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, cur_sub()));
            acc_q.push_back(cyc);
            acc_edge = cyc;
        end
        cyc++;
    end

    // Output monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_vs_busy", bus.in_ready, !bus.busy);
            if (bus.out_valid) begin
                chk("busy_in_done", bus.busy, 1);
                if (!prev_ov) chk("latency", (cyc - 1) - acc_edge, NS);
                if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_out: got out_valid with sum %0h, expected none", bus.out_sum);
                end else begin
                    chk("out_sum", bus.out_sum, sb_q[0].sum);
                    chk("out_cout", bus.out_cout, sb_q[0].cout);
                    if (bus.out_ready) begin
                        void'(sb_q.pop_front());
                        hs_edge = cyc;
                    end
                end
            end
            prev_ov = bus.out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
`ifdef RCA_SEQ_SUB_EN
        bus.in_sub   = sub;
`else
        if (sub) $display("note: subtract requested but feature not built");
`endif
        bus.in_valid = 1'b1;
    endtask

    task automatic wait_acc();
        int n0 = acc_q.size();
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            #1;
            if (acc_q.size() > n0) return;
        end
        n_chk++;
        $display("FAIL accept_timeout: operand not accepted, expected acceptance");
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
        drive(a, b, cin, sub);
        wait_acc();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && bus.in_ready) return;
        end
        n_chk++;
        $display("FAIL idle_timeout: %0d results outstanding, expected 0", sb_q.size());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n1, rel_edge;
        logic r;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
`ifdef RCA_SEQ_SUB_EN
        bus.in_sub    = 1'b0;
`endif
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_sum", bus.out_sum, 0);
        chk("rst_out_cout", bus.out_cout, 0);
        chk("rst_busy", bus.busy, 0);
        @(negedge clk) rst_n = 1'b1;

        // Wraparound carry
        send(12'hFFF, 12'h001, 1'b0, 1'b0);
        wait_idle();

        // Carry-in, busy/in_ready while running
        send(12'h123, 12'h456, 1'b1, 1'b0);
        chk("run_busy", bus.busy, 1);
        chk("run_in_ready", bus.in_ready, 0);
        wait_idle();

        // Backpressure with a pending operand
        bus.out_ready = 1'b0;
        send(12'h9C3, 12'h2B7, 1'b1, 1'b0);
        n1 = acc_q.size();
        drive(12'h321, 12'h0FE, 1'b0, 1'b0);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        repeat (10) @(negedge clk);
        chk("bp_out_valid", bus.out_valid, 1);
        chk("bp_no_accept", acc_q.size(), n1);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_acc();
        bus.in_valid = 1'b0;
        chk("accept_after_hs", acc_q[$], hs_edge + 1);
        wait_idle();

        // Back-to-back with in_valid held high
        n1 = acc_q.size();
        for (int i = 0; i < 3; i++) begin
            drive(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
            wait_acc();
        end
        bus.in_valid = 1'b0;
        chk("b2b_gap1", acc_q[n1+1] - acc_q[n1], NS + 2);
        chk("b2b_gap2", acc_q[n1+2] - acc_q[n1+1], NS + 2);
        wait_idle();

        // Reset in the middle of RUN
        send(W'($urandom), W'($urandom), 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        sb_q.delete();
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_sum", bus.out_sum, 0);
        chk("mid_rst_out_cout", bus.out_cout, 0);
        chk("mid_rst_busy", bus.busy, 0);
        drive(12'h0AA, 12'h055, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        rel_edge = cyc;
        wait_acc();
        bus.in_valid = 1'b0;
        chk("accept_after_release", acc_q[$], rel_edge);
        wait_idle();

`ifdef RCA_SEQ_SUB_EN
        send(12'h005, 12'h007, 1'b0, 1'b1);
        wait_idle();
        send(12'h007, 12'h005, 1'b0, 1'b1);
        wait_idle();
`endif

        // Randomized operations with random consumer stalls
        for (int i = 0; i < 30; i++) begin
            r = 1'($urandom);
            bus.out_ready = r;
`ifdef RCA_SEQ_SUB_EN
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
`else
            send(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
`endif
            if (!r) begin
                repeat ($urandom_range(NS + 1, NS + 6)) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
            wait_idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
